// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder.
//   - FSM state encoding (IDLE / RUN / DONE)
//   - clog2: ceiling log2 for sizing counters
//   - ndig:  number of digits a WIDTH-bit operand splits into
package adder_defs;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/digit_serial_adder_cla_digit.sv
// cla_digit: combinational DIGIT-bit carry-lookahead adder slice.
// Ports:
//   a, b   in  DIGIT  operand digits
//   cin    in  1      carry into bit 0
//   s      out DIGIT  sum digit
//   cout   out 1      carry out of the slice MSB
//   c_msb  out 1      carry into the slice MSB (used for overflow detection)
module cla_digit #(
  parameter int DIGIT = 5
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT-1:0] w_p;
  logic [DIGIT-1:0] w_g;
  logic [DIGIT:0]   w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Carry into bit i as a flat sum of products:
  //   c[i] = p[i-1..0]&cin | g[0]&p[i-1..1] | ... | g[i-1]
  // Every carry depends only on p, g and cin, never on a lower carry.
  function automatic logic carry_into(input int i, input logic [DIGIT-1:0] p,
                                      input logic [DIGIT-1:0] g, input logic c0);
    logic c;
    logic term;
    term = c0;
    for (int m = 0; m < i; m++) term = term & p[m];
    c = term;
    for (int j = 0; j < i; j++) begin
      term = g[j];
      for (int m = j + 1; m < i; m++) term = term & p[m];
      c = c | term;
    end
    return c;
  endfunction

  // NOTE: purely combinational block -- every output bit is assigned on every
  // pass (default first), so no latch can be inferred.
  always_comb begin
    w_c = '0;
    for (int i = 0; i <= DIGIT; i++) w_c[i] = carry_into(i, w_p, w_g, cin);
  end

  assign s     = w_p ^ w_c[DIGIT-1:0];
  assign cout  = w_c[DIGIT];
  assign c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle adder, Sum = A + B + CarryI, one DIGIT-bit
// carry-lookahead slice per clock, carry registered between digits.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (A, B, CarryI)
//   out_valid / out_ready result handshake (Sum, CarryO, Ovf)
//   Sum     WIDTH-bit result modulo 2^WIDTH
//   CarryO  unsigned carry out of bit WIDTH-1
//   Ovf     two's-complement overflow
module digit_serial_adder
  import adder_defs::*;
#(
  parameter int WIDTH = 15,
  parameter int DIGIT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryI,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryO,
  output logic             Ovf
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("digit_serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
  end

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry_o;
  logic             r_ovf;

  logic [DIGIT-1:0] w_s;
  logic             w_cout;
  logic             w_c_msb;
  logic             w_accept;
  logic             w_last;

  // Operands shift right so the current digit always sits in the low bits.
  cla_digit #(.DIGIT(DIGIT)) u_cla (
    .a     (r_a[DIGIT-1:0]),
    .b     (r_b[DIGIT-1:0]),
    .cin   (r_carry),
    .s     (w_s),
    .cout  (w_cout),
    .c_msb (w_c_msb)
  );

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_last   = (r_cnt == LAST);

  // Control and visible result registers: reset to a known state.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples its inputs from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sum     <= '0;
      r_carry_o <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) r_state <= ST_RUN;
        ST_RUN: begin
          for (int k = 0; k < NDIG; k++) begin
            if (r_cnt == CW'(k)) r_sum[k*DIGIT +: DIGIT] <= w_s;
          end
          if (w_last) begin
            r_state   <= ST_DONE;
            r_carry_o <= w_cout;
            // Carry into the MSB differs from carry out => signed overflow.
            r_ovf     <= w_cout ^ w_c_msb;
          end
        end
        ST_DONE: if (out_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset -- they are always loaded on accept
  // before they are read, and the FSM reset alone discards partial work.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a     <= A;
      r_b     <= B;
      r_carry <= CarryI;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_cout;
      if (!w_last) r_cnt <= r_cnt + CW'(1);
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign Sum       = r_sum;
  assign CarryO    = r_carry_o;
  assign Ovf       = r_ovf;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder. Four instances (WIDTH=15,
// DIGIT = 5, 1, 3, 15) share the stimulus; instance 0 (DIGIT=5) is the main
// device. Expected results come from plain integer arithmetic.
module tb_digit_serial_adder;

  localparam int W    = 15;
  localparam int NDUT = 4;

  function automatic int dig_of(input int i);
    case (i)
      0:       return 5;
      1:       return 1;
      2:       return 3;
      default: return 15;
    endcase
  endfunction

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          ci_in;

  logic          in_ready  [NDUT];
  logic          out_valid [NDUT];
  logic [W-1:0]  sum_o     [NDUT];
  logic          co_o      [NDUT];
  logic          ovf_o     [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    digit_serial_adder #(.WIDTH(W), .DIGIT(dig_of(g))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .A         (a_in),
      .B         (b_in),
      .CarryI    (ci_in),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .Sum       (sum_o[g]),
      .CarryO    (co_o[g]),
      .Ovf       (ovf_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer addition.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       output logic [W-1:0] s, output logic co, output logic ov);
    int unsigned full;
    full = int'(a) + int'(b) + int'(ci);
    s    = full[W-1:0];
    co   = full[W];
    ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endtask

  task automatic wait_all_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      ok = 1'b1;
      for (int i = 0; i < NDUT; i++) if (!in_ready[i]) ok = 1'b0;
      if (!ok) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // One transaction on all instances with out_ready held high; checks latency
  // and results of each instance. Called at a negedge.
  task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W-1:0] es;
    logic         eco;
    logic         eov;
    bit           done [NDUT];
    int           n_done;
    model(a, b, ci, es, eco, eov);
    wait_all_idle();
    out_ready = 1'b1;
    a_in      = a;
    b_in      = b;
    ci_in     = ci;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a_in     = W'($urandom);
    b_in     = W'($urandom);
    for (int i = 0; i < NDUT; i++) done[i] = 1'b0;
    n_done = 0;
    for (int n = 1; n <= 20 && n_done < NDUT; n++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        if (!done[i] && out_valid[i]) begin
          done[i] = 1'b1;
          n_done++;
          check($sformatf("latency[d%0d]", dig_of(i)), n, W / dig_of(i));
          check($sformatf("sum[d%0d]", dig_of(i)), sum_o[i], es);
          check($sformatf("carry[d%0d]", dig_of(i)), co_o[i], eco);
          check($sformatf("ovf[d%0d]", dig_of(i)), ovf_o[i], eov);
        end
      end
    end
    if (n_done < NDUT) check("result_timeout", n_done, NDUT);
  endtask

  logic [W-1:0] hold_sum;
  logic         hold_co;
  logic         hold_ov;
  logic [W-1:0] es;
  logic         eco;
  logic         eov;
  bit           seen;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    ci_in     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("rst_in_ready[%0d]", i), in_ready[i], 1);
      check($sformatf("rst_out_valid[%0d]", i), out_valid[i], 0);
      check($sformatf("rst_sum[%0d]", i), sum_o[i], 0);
      check($sformatf("rst_carry[%0d]", i), co_o[i], 0);
      check($sformatf("rst_ovf[%0d]", i), ovf_o[i], 0);
    end

    // Directed vectors, also cross-checked against hand-derived constants
    do_txn(15'h7FFF, 15'h0001, 1'b0);
    check("t1_sum", sum_o[0], 15'h0000);
    check("t1_carry", co_o[0], 1);
    check("t1_ovf", ovf_o[0], 0);
    do_txn(15'h3FFF, 15'h0001, 1'b0);
    check("t2_sum", sum_o[0], 15'h4000);
    check("t2_carry", co_o[0], 0);
    check("t2_ovf", ovf_o[0], 1);
    do_txn(15'h1234, 15'h0ABC, 1'b1);
    check("t3_sum", sum_o[0], 15'h1CF1);
    check("t3_carry", co_o[0], 0);
    check("t3_ovf", ovf_o[0], 0);
    do_txn(15'h7FFF, 15'h7FFF, 1'b1);
    do_txn(15'h4000, 15'h4000, 1'b0);
    do_txn(15'h0000, 15'h0000, 1'b0);

    // Random vectors
    for (int t = 0; t < 200; t++) begin
      do_txn(W'($urandom), W'($urandom), 1'($urandom));
    end

    // Backpressure on instance 0 (DIGIT=5)
    wait_all_idle();
    model(15'h2AAA, 15'h1555, 1'b1, es, eco, eov);
    out_ready = 1'b0;
    a_in      = 15'h2AAA;
    b_in      = 15'h1555;
    ci_in     = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(posedge clk);
      @(negedge clk);
      seen = out_valid[0];
    end
    check("bp_out_valid", out_valid[0], 1);
    check("bp_sum", sum_o[0], es);
    hold_sum = sum_o[0];
    hold_co  = co_o[0];
    hold_ov  = ovf_o[0];
    for (int n = 0; n < 10; n++) begin
      a_in     = W'($urandom);
      b_in     = W'($urandom);
      ci_in    = 1'($urandom);
      in_valid = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp_hold_sum[%0d]", n), sum_o[0], hold_sum);
      check($sformatf("bp_hold_co[%0d]", n), co_o[0], hold_co);
      check($sformatf("bp_hold_ovf[%0d]", n), ovf_o[0], hold_ov);
      check($sformatf("bp_in_ready[%0d]", n), in_ready[0], 0);
      check($sformatf("bp_valid[%0d]", n), out_valid[0], 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_ready", in_ready[0], 1);
    check("bp_release_out_valid", out_valid[0], 0);
    check("bp_release_sum_kept", sum_o[0], es);
    wait_all_idle();
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("bp_final_sum[d%0d]", dig_of(i)), sum_o[i], es);
      check($sformatf("bp_final_carry[d%0d]", dig_of(i)), co_o[i], eco);
    end

    // Reset during the 2nd RUN cycle
    a_in     = 15'h1111;
    b_in     = 15'h2222;
    ci_in    = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("mid_rst_in_ready[%0d]", i), in_ready[i], 1);
      check($sformatf("mid_rst_out_valid[%0d]", i), out_valid[i], 0);
      check($sformatf("mid_rst_sum[%0d]", i), sum_o[i], 0);
    end
    do_txn(15'h5A5A, 15'h1234, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
